// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, ALU ops,
// mux selects and the bundled control word produced by the output decoder.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_R_EXEC   = 4'd6,
    S_R_WB     = 4'd7,
    S_IMM_EXEC = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_R   = 3'b100;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       ext_zero;
    logic       done;
    logic       illegal;
  } ctrl_t;

  function automatic logic is_known_op(input logic [5:0] op);
    return (op == OP_R)  || (op == OP_ADDI) || (op == OP_ORI) || (op == OP_BEQ) ||
           (op == OP_LW) || (op == OP_SW)   || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: opcode/ready in, control strobes and status out.
interface multicycle_ctrl_if #(parameter int CNT_W = 16);
  logic [5:0]       instr_op_i;
  logic             mem_ready_i;
  logic             pc_write_o;
  logic             pc_write_cond_o;
  logic [1:0]       pc_source_o;
  logic             ir_write_o;
  logic             i_or_d_o;
  logic             mem_read_o;
  logic             mem_write_o;
  logic             reg_write_o;
  logic             reg_dst_o;
  logic             mem_to_reg_o;
  logic             alu_src_a_o;
  logic [1:0]       alu_src_b_o;
  logic [2:0]       alu_op_o;
  logic             ext_zero_o;
  logic             done_o;
  logic             illegal_o;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] retired_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, ext_zero_o, done_o, illegal_o,
           state_o, retired_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  pc_write_o, pc_write_cond_o, pc_source_o, ir_write_o, i_or_d_o,
           mem_read_o, mem_write_o, reg_write_o, reg_dst_o, mem_to_reg_o,
           alu_src_a_o, alu_src_b_o, alu_op_o, ext_zero_o, done_o, illegal_o,
           state_o, retired_o
  );
endinterface

// File: rtl/multicycle_ctrl_out.sv
// Moore-style control decode: (state, opcode, mem_ready) -> full control word.
module multicycle_ctrl_out
  import ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] op_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      S_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      S_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH;
        ctrl_o.illegal   = !is_known_op(op_i);
      end
      S_MEM_ADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_MEM_RD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
        ctrl_o.done       = 1'b1;
      end
      S_MEM_WR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.done      = mem_ready_i;
      end
      S_R_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALU_R;
      end
      S_R_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      S_IMM_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
        if (op_i == OP_ORI) begin
          ctrl_o.alu_op   = ALU_OR;
          ctrl_o.ext_zero = 1'b1;
        end
      end
      S_IMM_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.done      = 1'b1;
      end
      S_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALU_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
        ctrl_o.done          = 1'b1;
      end
      S_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
        ctrl_o.done      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register, latched opcode, next-state logic
// and retired-instruction counter; output decode lives in multicycle_ctrl_out.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  multicycle_ctrl_if.master    bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  ctrl_t            ctrl_raw, ctrl;

  // In DECODE the IR opcode is live and op_q is still stale, so both the
  // next-state logic and the decoder see the opcode being latched this cycle.
  assign op_d = (state_q == S_DECODE) ? bus.instr_op_i : op_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = bus.mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_d)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_R_EXEC;
          OP_ADDI, OP_ORI: state_d = S_IMM_EXEC;
          OP_BEQ:          state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR: state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = bus.mem_ready_i ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   state_d = bus.mem_ready_i ? S_FETCH : S_MEM_WR;
      S_R_EXEC:   state_d = S_R_WB;
      S_IMM_EXEC: state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  multicycle_ctrl_out u_out (
    .state_i     (state_q),
    .op_i        (op_d),
    .mem_ready_i (bus.mem_ready_i),
    .ctrl_o      (ctrl_raw)
  );

  // Reset forces every strobe low combinationally so an aborted store never
  // writes during the reset cycle.
  assign ctrl      = rst_i ? '0 : ctrl_raw;
  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, ctrl.done};

  assign bus.pc_write_o      = ctrl.pc_write;
  assign bus.pc_write_cond_o = ctrl.pc_write_cond;
  assign bus.pc_source_o     = ctrl.pc_source;
  assign bus.ir_write_o      = ctrl.ir_write;
  assign bus.i_or_d_o        = ctrl.i_or_d;
  assign bus.mem_read_o      = ctrl.mem_read;
  assign bus.mem_write_o     = ctrl.mem_write;
  assign bus.reg_write_o     = ctrl.reg_write;
  assign bus.reg_dst_o       = ctrl.reg_dst;
  assign bus.mem_to_reg_o    = ctrl.mem_to_reg;
  assign bus.alu_src_a_o     = ctrl.alu_src_a;
  assign bus.alu_src_b_o     = ctrl.alu_src_b;
  assign bus.alu_op_o        = ctrl.alu_op;
  assign bus.ext_zero_o      = ctrl.ext_zero;
  assign bus.done_o          = ctrl.done;
  assign bus.illegal_o       = ctrl.illegal;
  assign bus.state_o         = rst_i ? 4'd0 : state_q;
  assign bus.retired_o       = retired_q;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multicycle control unit for the lab CPU datapath. It sequences one shared ALU, one unified instruction/data memory and the register file across FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states, driven by the 6-bit opcode held in the instruction register. It replaces per-instruction combinational decoding with a Moore FSM plus a memory-ready handshake. It also counts retired instructions.

## Interface
- CNT_W, 16, width of retired-instruction counter
- clk_i  in  1  clock, all state updates on rising edge
- rst_i  in  1  synchronous reset, active-high
- instr_op_i  in  6  opcode from IR (instr[31:26])
- mem_ready_i  in  1  memory completes current read/write this cycle
- pc_write_o  out  1  unconditional PC load
- pc_write_cond_o  out  1  PC load if datapath zero flag set
- pc_source_o  out  2  00 ALU result, 01 ALUOut, 10 jump target
- ir_write_o  out  1  load IR from memory data
- i_or_d_o  out  1  memory address: 0 PC, 1 ALUOut
- mem_read_o / mem_write_o  out  1 each  memory strobes
- reg_write_o  out  1  register file write
- reg_dst_o  out  1  0 rt, 1 rd
- mem_to_reg_o  out  1  0 ALUOut, 1 MDR
- alu_src_a_o  out  1  0 PC, 1 rs
- alu_src_b_o  out  2  00 rt, 01 const 4, 10 ext imm, 11 ext imm<<2
- alu_op_o  out  3  000 add, 001 sub, 010 or, 100 R-type (funct decides)
- ext_zero_o  out  1  1 zero-extend immediate (ori), else sign-extend
- done_o  out  1  one-cycle pulse at instruction retirement
- illegal_o  out  1  one-cycle pulse on unknown opcode
- state_o  out  4  current state encoding (debug)
- retired_o  out  CNT_W  retired instruction count

## Operation
- Opcodes: 000000 R, 001000 addi, 001101 ori, 000100 beq, 100011 lw, 101011 sw, 000010 j.
- op_q latches instr_op_i in DECODE. Later states use only op_q.
- Outputs are decoded from state, op_q and mem_ready_i. Any output not listed for a state is 0.
- FETCH (0):
  - Drives mem_read=1, i_or_d=0, src_a=0, src_b=01, alu_op=000, pc_source=00.
  - When mem_ready_i=1, also drives ir_write=1 and pc_write=1, then goes to DECODE. Otherwise stays in FETCH.
- DECODE (1):
  - Drives src_a=0, src_b=11, alu_op=000 to compute the branch target.
  - Next state by opcode: lw/sw→MEM_ADDR, R→R_EXEC, addi/ori→IMM_EXEC, beq→BRANCH, j→JUMP.
  - Unknown opcode: illegal_o=1, next state FETCH.
- MEM_ADDR (2): src_a=1, src_b=10, alu_op=000. Next MEM_RD for lw, MEM_WR for sw.
- MEM_RD (3): mem_read=1, i_or_d=1. Holds until mem_ready_i=1, then MEM_WB.
- MEM_WB (4): reg_write=1, reg_dst=0, mem_to_reg=1, done. Next FETCH.
- MEM_WR (5): mem_write=1, i_or_d=1. Holds until mem_ready_i=1; then done and next FETCH.
- R_EXEC (6): src_a=1, src_b=00, alu_op=100. Next R_WB.
- R_WB (7): reg_write=1, reg_dst=1, done. Next FETCH.
- IMM_EXEC (8): src_a=1, src_b=10; alu_op=000 for addi, 010 with ext_zero=1 for ori. Next IMM_WB.
- IMM_WB (9): reg_write=1, reg_dst=0, done. Next FETCH.
- BRANCH (10): src_a=1, src_b=00, alu_op=001, pc_write_cond=1, pc_source=01, done. Next FETCH.
- JUMP (11): pc_write=1, pc_source=10, done. Next FETCH.
- Encodings 12–15 are unreachable. If entered, the FSM goes to FETCH with all strobes 0.
- retired_o increments by 1 on every cycle where done_o=1. It wraps from 2^CNT_W−1 to 0. Illegal opcodes are not counted.

## Timing
- Reset:
  - While rst_i=1, all strobes and mux selects read 0, done_o=0, illegal_o=0, state_o=0.
  - The first edge with rst_i=1 clears state to FETCH, op_q to 0 and retired_o to 0.
  - FETCH strobes begin in the first cycle with rst_i=0.
- Reset mid-instruction aborts it. mem_write_o is 0 in the reset cycle, and no done_o pulse is issued.
- mem_ready_i is sampled only in FETCH, MEM_RD and MEM_WR, and is ignored elsewhere. Strobes stay asserted through all wait cycles.
- CPI with mem_ready_i tied to 1: beq 3, j 3, R 4, addi/ori 4, sw 4, lw 5. Each wait cycle in FETCH, MEM_RD or MEM_WR adds 1.
- done_o is coincident with the architectural write of the retiring instruction: the register write, memory write, or PC update.

## Structure
- Package ctrl_pkg holds:
  - state encoding constants;
  - opcode constants;
  - ALU_op constants 000/001/010/100, shared with the single-cycle decoder;
  - alu_src_b and pc_source select constants.
- Sub-module multicycle_ctrl_out: purely combinational decode of (state, op_q, mem_ready_i) into all control outputs.
- The top level holds the state register, op_q, the next-state logic and the counter.

## Test plan
- Reset, then an R-type (op 000000) with mem_ready_i=1 → states 0,1,6,7,0. reg_write_o=1 with reg_dst_o=1 only in state 7. retired_o=1.
- lw (100011) with 2 wait cycles in MEM_RD → states 0,1,2,3,3,3,4. mem_read_o=1 and i_or_d_o=1 for 3 cycles. 7 cycles total.
- beq (000100) → 3 cycles. pc_write_cond_o=1, alu_op_o=001, pc_source_o=01 in state 10.
- ori (001101) → ext_zero_o=1 and alu_op_o=010 in IMM_EXEC. addi → ext_zero_o=0, alu_op_o=000.
- Opcode 111111 → illegal_o pulses in DECODE, next state FETCH, retired_o unchanged, no write strobes.
- Assert rst_i during MEM_WR with mem_ready_i=0 → mem_write_o=0 that cycle, state_o=0 and retired_o=0 next cycle. Also check counter wrap with CNT_W=2 after 4 retirements (retired_o=0).
